// File: rtl/jtcop_mcu_mbox_pkg.sv
// Shared port-2 strobe bit map, empty-read value and helpers for the MCU mailbox.
// Pure definitions; no logic, no latency, no flow control.
package jtcop_mcu_mbox_pkg;

    localparam int INTMASK = 3;
    localparam int RDHI    = 4;
    localparam int RDLO    = 5;
    localparam int WRLO    = 6;
    localparam int WRHI    = 7;

    localparam logic [7:0] EMPTY_RD = 8'hFF;

    // Registered copies of every strobe that is edge-detected.
    typedef struct packed {
        logic       wr;
        logic       rd;
        logic [3:0] strb;
    } edge_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/jtcop_mcu_fifo.sv
// Command word queue: storage, wrapping pointers, occupancy, full and sticky overflow.
// Push/pop take effect on the next clock; a push while full is dropped unless a pop frees the slot.
module jtcop_mcu_fifo
    import jtcop_mcu_mbox_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [15:0]   din,
    output logic [15:0]   head,
    output logic [CW-1:0] cnt,
    output logic          full,
    output logic          ovf
);

    localparam int PW = ptr_w(DEPTH);

    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          accept;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full   = (cnt == CW'(DEPTH));
    assign accept = push & (~full | pop);
    assign head   = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
        end else begin
            if (accept)
                wptr <= nxt(wptr);
            if (pop)
                rptr <= nxt(rptr);
            if (accept && !pop)
                cnt <= cnt + 1'b1;
            else if (pop && !accept)
                cnt <= cnt - 1'b1;
            if (push && !accept)
                ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            mem[wptr] <= din;
    end

endmodule

// File: rtl/jtcop_mcu_mbox.sv
// Mailbox between the 68000 bus and i8751 ports: command queue, INT1, reply register, overflow.
// Outputs registered, one cycle after the sampled edge; no stall, full queue drops (or overwrites).
// JTCOP_MCU_MBOX_FIFO_EN selects the DEPTH-word queue; otherwise a single command register.
module jtcop_mcu_mbox
    import jtcop_mcu_mbox_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          main_wr,
    input  logic [15:0]   main_din,
    input  logic          main_rd,
    output logic [15:0]   main_dout,
    output logic          reply_vld,
    input  logic [7:0]    p0_o,
    input  logic [7:0]    p2_o,
    output logic [7:0]    p0_i,
    output logic          mcu_intn,
    output logic [CW-1:0] cmd_cnt,
    output logic          cmd_full,
    output logic          ovf
);

    edge_t       prev;
    logic [3:0]  strb_rise;
    logic        push;
    logic        ack;
    logic        rdhi_rise;
    logic        rdlo_rise;
    logic        wrlo_rise;
    logic        wrhi_rise;
    logic        empty;
    logic        pop;
    logic [15:0] head;
    logic [7:0]  staged;

    assign push      = main_wr & ~prev.wr;
    assign ack       = main_rd & ~prev.rd;
    assign strb_rise = p2_o[7:4] & ~prev.strb;
    assign rdhi_rise = strb_rise[RDHI-4];
    assign rdlo_rise = strb_rise[RDLO-4];
    assign wrlo_rise = strb_rise[WRLO-4];
    assign wrhi_rise = strb_rise[WRHI-4];
    assign empty     = (cmd_cnt == '0);
    assign pop       = rdlo_rise & ~empty;

`ifdef JTCOP_MCU_MBOX_FIFO_EN
    jtcop_mcu_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .din  (main_din),
        .head (head),
        .cnt  (cmd_cnt),
        .full (cmd_full),
        .ovf  (ovf)
    );
`else
    logic [15:0]   word;
    logic          held;
    logic [CW-1:0] unused_depth;

    assign unused_depth = CW'(DEPTH);

    // A push onto a held word overwrites it; only a same-cycle pop makes that legal.
    always_ff @(posedge clk) begin
        if (rst) begin
            word <= '0;
            held <= 1'b0;
            ovf  <= 1'b0;
        end else if (push) begin
            word <= main_din;
            held <= 1'b1;
            if (held && !pop)
                ovf <= 1'b1;
        end else if (pop) begin
            held <= 1'b0;
        end
    end

    assign head     = word;
    assign cmd_cnt  = CW'(held);
    assign cmd_full = cmd_cnt[0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            prev      <= '1;
            p0_i      <= EMPTY_RD;
            mcu_intn  <= 1'b1;
            staged    <= '0;
            main_dout <= '0;
            reply_vld <= 1'b0;
        end else begin
            prev     <= '{wr: main_wr, rd: main_rd, strb: p2_o[7:4]};
            mcu_intn <= ~(p2_o[INTMASK] & ~empty);

            if (rdlo_rise)
                p0_i <= empty ? EMPTY_RD : head[7:0];
            else if (rdhi_rise)
                p0_i <= empty ? EMPTY_RD : head[15:8];

            if (wrlo_rise)
                staged <= p0_o;

            if (wrhi_rise) begin
                main_dout <= {p0_o, staged};
                reply_vld <= 1'b1;
            end else if (ack) begin
                reply_vld <= 1'b0;
            end
        end
    end

    logic unused_p2;
    assign unused_p2 = &{1'b0, p2_o[2:0]};

endmodule

// File: tb/tb_jtcop_mcu_mbox.sv
// Bench for jtcop_mcu_mbox: directed scenarios plus randomized traffic against a queue model.
module tb_jtcop_mcu_mbox;

    localparam int DEPTH = 4;
    localparam int CW    = 5;
`ifdef JTCOP_MCU_MBOX_FIFO_EN
    localparam bit FIFO = 1'b1;
    localparam int CAP  = DEPTH;
`else
    localparam bit FIFO = 1'b0;
    localparam int CAP  = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          main_wr;
    logic [15:0]   main_din;
    logic          main_rd;
    logic [15:0]   main_dout;
    logic          reply_vld;
    logic [7:0]    p0_o;
    logic [7:0]    p2_o;
    logic [7:0]    p0_i;
    logic          mcu_intn;
    logic [CW-1:0] cmd_cnt;
    logic          cmd_full;
    logic          ovf;

    always #5 clk = ~clk;

    jtcop_mcu_mbox #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .main_wr   (main_wr),
        .main_din  (main_din),
        .main_rd   (main_rd),
        .main_dout (main_dout),
        .reply_vld (reply_vld),
        .p0_o      (p0_o),
        .p2_o      (p2_o),
        .p0_i      (p0_i),
        .mcu_intn  (mcu_intn),
        .cmd_cnt   (cmd_cnt),
        .cmd_full  (cmd_full),
        .ovf       (ovf)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [15:0] q[$];
    bit          m_ovf;
    logic [7:0]  m_p0i;
    bit          m_intn;
    logic [15:0] m_dout;
    bit          m_vld;
    logic [7:0]  m_stg;
    bit          pv_wr;
    bit          pv_rd;
    logic [3:0]  pv_strb;

    task automatic model_step();
        bit         wr_r;
        bit         rd_r;
        logic [3:0] s_r;
        if (rst) begin
            q.delete();
            m_ovf = 0; m_p0i = 8'hFF; m_intn = 1; m_dout = 16'h0; m_vld = 0; m_stg = 8'h0;
            pv_wr = 1; pv_rd = 1; pv_strb = 4'hF;
        end else begin
            wr_r = main_wr && !pv_wr;
            rd_r = main_rd && !pv_rd;
            s_r  = p2_o[7:4] & ~pv_strb;
            m_intn = !(p2_o[3] && q.size() != 0);
            if (s_r[1] || s_r[0]) begin
                if (q.size() == 0)
                    m_p0i = 8'hFF;
                else if (s_r[1]) begin
                    m_p0i = q[0][7:0];
                    void'(q.pop_front());
                end else
                    m_p0i = q[0][15:8];
            end
            if (wr_r) begin
                if (q.size() < CAP)
                    q.push_back(main_din);
                else begin
                    m_ovf = 1;
                    if (!FIFO) q[q.size()-1] = main_din;
                end
            end
            if (s_r[3]) begin
                m_dout = {p0_o, m_stg};
                m_vld  = 1;
            end else if (rd_r)
                m_vld = 0;
            if (s_r[2])
                m_stg = p0_o;
            pv_wr = main_wr; pv_rd = main_rd; pv_strb = p2_o[7:4];
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] w);
        main_din = w; main_wr = 1'b1; tick();
        main_wr = 1'b0; tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; main_wr = 0; main_rd = 0; p2_o = 8'h08; tick();
        rst = 1'b0; tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; main_wr = 1'b1; main_rd = 1'b1; main_din = 16'hBEEF;
        p0_o = 8'h00; p2_o = 8'hFF;
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        n_cmp++; if (p0_i !== 8'hFF) begin n_bad++; $display("FAIL reset_p0i: got %h want ff", p0_i); end
        n_cmp++; if (mcu_intn !== 1'b1) begin n_bad++; $display("FAIL reset_intn: got %b want 1", mcu_intn); end
        n_cmp++; if (cmd_cnt !== '0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", cmd_cnt); end
        n_cmp++; if (reply_vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld: got %b want 0", reply_vld); end
        n_cmp++; if (main_dout !== 16'h0) begin n_bad++; $display("FAIL reset_dout: got %h want 0000", main_dout); end
        n_cmp++; if (ovf !== 1'b0 || cmd_full !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got ovf=%b full=%b want 0 0", ovf, cmd_full); end
        main_wr = 1'b0; main_rd = 1'b0; p2_o = 8'h08; tick();
    endtask

    task automatic test_push_pop();
        main_din = 16'h1234; main_wr = 1'b1; tick();
        n_cmp++; if (cmd_cnt !== 5'd1) begin n_bad++; $display("FAIL push_cnt: got %0d want 1", cmd_cnt); end
        n_cmp++; if (mcu_intn !== 1'b1) begin n_bad++; $display("FAIL push_intn_n1: got %b want 1", mcu_intn); end
        main_wr = 1'b0; tick();
        n_cmp++; if (mcu_intn !== 1'b0) begin n_bad++; $display("FAIL push_intn_n2: got %b want 0", mcu_intn); end
        p2_o = 8'h18; tick();
        n_cmp++; if (p0_i !== 8'h12) begin n_bad++; $display("FAIL read_hi: got %h want 12", p0_i); end
        n_cmp++; if (cmd_cnt !== 5'd1) begin n_bad++; $display("FAIL read_hi_nopop: got %0d want 1", cmd_cnt); end
        p2_o = 8'h08; tick();
        p2_o = 8'h28; tick();
        n_cmp++; if (p0_i !== 8'h34) begin n_bad++; $display("FAIL read_lo: got %h want 34", p0_i); end
        n_cmp++; if (cmd_cnt !== 5'd0) begin n_bad++; $display("FAIL pop_cnt: got %0d want 0", cmd_cnt); end
        p2_o = 8'h08; tick();
        n_cmp++; if (mcu_intn !== 1'b1) begin n_bad++; $display("FAIL pop_intn: got %b want 1", mcu_intn); end
    endtask

    task automatic test_overflow();
        do_reset();
`ifdef JTCOP_MCU_MBOX_FIFO_EN
        for (int k = 1; k <= 5; k++) push_word(16'(k));
        n_cmp++; if (cmd_full !== 1'b1) begin n_bad++; $display("FAIL ovf_full: got %b want 1", cmd_full); end
        n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", ovf); end
        n_cmp++; if (cmd_cnt !== 5'd4) begin n_bad++; $display("FAIL ovf_cnt: got %0d want 4", cmd_cnt); end
        for (int k = 1; k <= 5; k++) begin
            logic [7:0] want;
            want = (k <= 4) ? 8'(k) : 8'hFF;
            p2_o = 8'h28; tick();
            n_cmp++; if (p0_i !== want) begin n_bad++; $display("FAIL ovf_pop%0d: got %h want %h", k, p0_i, want); end
            p2_o = 8'h08; tick();
        end
`else
        push_word(16'h1111);
        push_word(16'h2222);
        n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", ovf); end
        n_cmp++; if (cmd_cnt !== 5'd1 || cmd_full !== 1'b1) begin n_bad++; $display("FAIL ovf_cnt: got %0d/%b want 1/1", cmd_cnt, cmd_full); end
        p2_o = 8'h18; tick();
        n_cmp++; if (p0_i !== 8'h22) begin n_bad++; $display("FAIL ovf_hi: got %h want 22", p0_i); end
        p2_o = 8'h08; tick();
        p2_o = 8'h28; tick();
        n_cmp++; if (p0_i !== 8'h22) begin n_bad++; $display("FAIL ovf_lo: got %h want 22", p0_i); end
        p2_o = 8'h08; tick();
        n_cmp++; if (cmd_cnt !== 5'd0) begin n_bad++; $display("FAIL ovf_drain: got %0d want 0", cmd_cnt); end
`endif
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_q[$];
        do_reset();
        for (int k = 0; k < CAP; k++) push_word(16'h00A1 + 16'(k));
        for (int k = 1; k < CAP; k++) exp_q.push_back(8'hA1 + 8'(k));
        exp_q.push_back(8'hB0);
        n_cmp++; if (cmd_cnt !== CW'(CAP)) begin n_bad++; $display("FAIL fpp_fill: got %0d want %0d", cmd_cnt, CAP); end
        main_din = 16'h00B0; main_wr = 1'b1; p2_o = 8'h28; tick();
        n_cmp++; if (p0_i !== 8'hA1) begin n_bad++; $display("FAIL fpp_head: got %h want a1", p0_i); end
        n_cmp++; if (cmd_cnt !== CW'(CAP)) begin n_bad++; $display("FAIL fpp_cnt: got %0d want %0d", cmd_cnt, CAP); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL fpp_ovf: got %b want 0", ovf); end
        main_wr = 1'b0; p2_o = 8'h08; tick();
        foreach (exp_q[i]) begin
            p2_o = 8'h28; tick();
            n_cmp++; if (p0_i !== exp_q[i]) begin n_bad++; $display("FAIL fpp_pop%0d: got %h want %h", i, p0_i, exp_q[i]); end
            p2_o = 8'h08; tick();
        end
        n_cmp++; if (cmd_cnt !== 5'd0) begin n_bad++; $display("FAIL fpp_drain: got %0d want 0", cmd_cnt); end
    endtask

    task automatic test_reply();
        p0_o = 8'hCD; p2_o = 8'h48; tick();
        p2_o = 8'h08; p0_o = 8'hAB; tick();
        p2_o = 8'h88; tick();
        n_cmp++; if (main_dout !== 16'hABCD) begin n_bad++; $display("FAIL reply_dout: got %h want abcd", main_dout); end
        n_cmp++; if (reply_vld !== 1'b1) begin n_bad++; $display("FAIL reply_vld: got %b want 1", reply_vld); end
        p2_o = 8'h08; tick();
        main_rd = 1'b1; tick();
        n_cmp++; if (reply_vld !== 1'b0) begin n_bad++; $display("FAIL reply_ack: got %b want 0", reply_vld); end
        main_rd = 1'b0; tick();
        p0_o = 8'h5A; p2_o = 8'h88; main_rd = 1'b1; tick();
        n_cmp++; if (reply_vld !== 1'b1) begin n_bad++; $display("FAIL reply_commit_wins: got %b want 1", reply_vld); end
        n_cmp++; if (main_dout !== 16'h5ACD) begin n_bad++; $display("FAIL reply_dout2: got %h want 5acd", main_dout); end
        p2_o = 8'h08; main_rd = 1'b0; tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 99) == 0);
            main_wr  = 1'($urandom_range(0, 1));
            main_rd  = 1'($urandom_range(0, 1));
            main_din = 16'($urandom);
            p0_o     = 8'($urandom);
            p2_o     = 8'($urandom);
            p2_o[5]  = ($urandom_range(0, 3) == 0);
            tick();
            n_cmp++; if (cmd_cnt !== CW'(q.size())) begin n_bad++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", i, cmd_cnt, q.size()); end
            n_cmp++; if (cmd_full !== (q.size() == CAP)) begin n_bad++; $display("FAIL rnd_full@%0d: got %b want %b", i, cmd_full, q.size() == CAP); end
            n_cmp++; if (ovf !== m_ovf) begin n_bad++; $display("FAIL rnd_ovf@%0d: got %b want %b", i, ovf, m_ovf); end
            n_cmp++; if (p0_i !== m_p0i) begin n_bad++; $display("FAIL rnd_p0i@%0d: got %h want %h", i, p0_i, m_p0i); end
            n_cmp++; if (mcu_intn !== m_intn) begin n_bad++; $display("FAIL rnd_intn@%0d: got %b want %b", i, mcu_intn, m_intn); end
            n_cmp++; if (main_dout !== m_dout) begin n_bad++; $display("FAIL rnd_dout@%0d: got %h want %h", i, main_dout, m_dout); end
            n_cmp++; if (reply_vld !== m_vld) begin n_bad++; $display("FAIL rnd_vld@%0d: got %b want %b", i, reply_vld, m_vld); end
        end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_overflow();
        test_full_push_pop();
        test_reply();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
